// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave in front of a DFFRAM macro.
// The SRAM read and write takes one cycle and has 4 byte lanes.
// Reads and writes complete with zero wait states. This works
// because of a one-entry write buffer with read-after-write
// forwarding. An illegal transfer gets a two-cycle ERROR response
// and never reaches the SRAM.
// Ports:
//   HCLK, HRESET         clock and synchronous active-high reset
//   HSEL/HADDR/HTRANS/   AHB-Lite address phase
//   HWRITE/HSIZE/HREADY
//   HWDATA               AHB-Lite write data (data phase)
//   HREADYOUT/HRESP/     slave response and read data
//   HRDATA
//   SRAMRDATA            macro read data, one cycle after a read enable
//   SRAMWEN/SRAMWDATA/   macro byte write enables, data, enable and
//   SRAMCS0/SRAMADDR     word address
module ahb_sram_ctrl #(
  parameter int AW = 15
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-1:0] SRAMADDR
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic          wr_dp_q, wr_dp_d;
  logic          rd_dp_q, rd_dp_d;
  logic [3:0]    lanes_q, lanes_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          buf_v_q, buf_v_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_wen_q, buf_wen_d;
  logic [31:0]   buf_data_q, buf_data_d;

  logic       acc, legal, p1, p2, p3;
  logic [3:0] lanes;

  always_comb begin
    acc = HSEL & HTRANS[1] & HREADY & ((state_q == S_IDLE) | (state_q == S_ERR2));

    legal = 1'b1;
    lanes = 4'b0000;
    case (HSIZE)
      3'd0: lanes = 4'b0001 << HADDR[1:0];
      3'd1: begin
        lanes = HADDR[1] ? 4'b1100 : 4'b0011;
        legal = ~HADDR[0];
      end
      3'd2: begin
        lanes = 4'b1111;
        legal = (HADDR[1:0] == 2'b00);
      end
      default: legal = 1'b0;
    endcase

    // Reset masks every port request, so a pending buffered write is dropped.
    p1 = ~HRESET & acc & legal & ~HWRITE;
    p2 = ~HRESET & wr_dp_q & ~p1;
    p3 = ~HRESET & buf_v_q & ~p1 & ~p2;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc && !legal) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = (acc && !legal) ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    HREADYOUT = (state_q != S_ERR1);
    HRESP     = (state_q != S_IDLE);
  end

  always_comb begin
    wr_dp_d    = acc & legal & HWRITE;
    rd_dp_d    = acc & legal & ~HWRITE;
    lanes_d    = lanes_q;
    addr_d     = addr_q;
    buf_v_d    = buf_v_q;
    buf_addr_d = buf_addr_q;
    buf_wen_d  = buf_wen_q;
    buf_data_d = buf_data_q;

    if (acc && legal) begin
      lanes_d = lanes;
      addr_d  = HADDR[AW+1:2];
    end

    // A write data phase that loses the port to a read address phase
    // is parked in the buffer.
    if (wr_dp_q && p1) begin
      buf_v_d    = 1'b1;
      buf_addr_d = addr_q;
      buf_wen_d  = lanes_q;
      buf_data_d = HWDATA;
    end else if (p3) begin
      buf_v_d = 1'b0;
    end

    SRAMCS0   = p1 | p2 | p3;
    SRAMWEN   = '0;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    if (p1) begin
      SRAMADDR = HADDR[AW+1:2];
    end else if (p2) begin
      SRAMWEN   = lanes_q;
      SRAMADDR  = addr_q;
      SRAMWDATA = HWDATA;
    end else if (p3) begin
      SRAMWEN   = buf_wen_q;
      SRAMADDR  = buf_addr_q;
      SRAMWDATA = buf_data_q;
    end

    HRDATA = '0;
    if (rd_dp_q) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (buf_v_q && (buf_addr_q == addr_q) && buf_wen_q[n])
          HRDATA[8*n +: 8] = buf_data_q[8*n +: 8];
        else
          HRDATA[8*n +: 8] = SRAMRDATA[8*n +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      wr_dp_q    <= 1'b0;
      rd_dp_q    <= 1'b0;
      lanes_q    <= '0;
      addr_q     <= '0;
      buf_v_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_wen_q  <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_dp_q    <= wr_dp_d;
      rd_dp_q    <= rd_dp_d;
      lanes_q    <= lanes_d;
      addr_q     <= addr_d;
      buf_v_q    <= buf_v_d;
      buf_addr_q <= buf_addr_d;
      buf_wen_q  <= buf_wen_d;
      buf_data_q <= buf_data_d;
    end
  end

  // A buffered entry must have flushed before the next write data phase.
  a_no_buf_contention: assert property (@(posedge HCLK) disable iff (HRESET)
    !(buf_v_q && wr_dp_q));

endmodule
